// File: rtl/net_bus_pkg.sv
// Shared definitions for the NetBus synchronous FIFO: pointer sizing and the status bundle.
package net_bus_pkg;

   localparam int PTR_EXTRA_BITS = 1;

   // Pointers carry one extra wrap bit above the RAM address bits.
   function automatic int ptr_width(input int depth);
      return depth + PTR_EXTRA_BITS;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
      logic ovf;
      logic udf;
   } fifo_status_t;

endpackage

// File: rtl/net_bus_sync_fifo_mem.sv
// Simple dual-port RAM for the NetBus FIFO: synchronous write, registered read, array not reset.
module net_bus_sync_fifo_mem
   import net_bus_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/net_bus_sync_fifo.sv
// Single-clock NetBus FIFO: pointers, registered flags, sticky errors and an optional
// first-word-fall-through prefetch stage around a registered-read RAM.
module net_bus_sync_fifo
   import net_bus_pkg::*;
#(
   parameter int RAM_WIDTH     = 16,
   parameter int RAM_DEPTH     = 4,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [RAM_WIDTH-1:0] DIN,
   input  logic                 WEN,
   input  logic                 REN,
   input  logic                 CLR_ERR,
   output logic [RAM_WIDTH-1:0] DOUT,
   output logic                 DVALID,
   output logic                 FULL,
   output logic                 EMPTY,
   output logic                 AFULL,
   output logic                 AEMPTY,
   output logic [RAM_DEPTH:0]   LEVEL,
   output logic                 OVF,
   output logic                 UDF
);

   localparam int PTR_W = ptr_width(RAM_DEPTH);
   localparam logic [PTR_W-1:0] AFULL_T  = PTR_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] AEMPTY_T = PTR_W'(AEMPTY_THRESH);
   localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0,
                                           aempty: 1'b1, ovf: 1'b0, udf: 1'b0};

   if (AFULL_THRESH < 0 || AFULL_THRESH > (1 << RAM_DEPTH)) begin : g_bad_afull
      $error("net_bus_sync_fifo: AFULL_THRESH outside 0..(1<<RAM_DEPTH)");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << RAM_DEPTH)) begin : g_bad_aempty
      $error("net_bus_sync_fifo: AEMPTY_THRESH outside 0..(1<<RAM_DEPTH)");
   end

   logic [PTR_W-1:0]     wptr, rptr, wptr_n, rptr_n, st_count, level_q, level_n;
   logic                 wr_accept, rd_accept, pop, load_out;
   logic                 pf_valid, pf_valid_n, out_valid, out_valid_n;
   logic [RAM_WIDTH-1:0] rd_data, dout_q, dout_n;
   logic [RAM_DEPTH-1:0] rd_addr;
   fifo_status_t         status_q, status_n;

   net_bus_sync_fifo_mem #(
      .WIDTH  (RAM_WIDTH),
      .ADDR_W (RAM_DEPTH)
   ) u_mem (
      .clk     (CLK),
      .wr_en   (wr_accept & ~RST),
      .wr_addr (wptr[RAM_DEPTH-1:0]),
      .wr_data (DIN),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // pf_valid marks rd_data as a live RAM word. In FWFT mode it mirrors mem[rptr], which is
   // still counted as storage until it moves into the output register, so LEVEL tops out at
   // capacity+1 and the RAM word at rptr can never be overwritten while it is being shown.
   always_comb begin
      st_count    = wptr - rptr;
      wr_accept   = WEN & ~status_q.full;
      rd_accept   = REN & ~status_q.empty;
      wptr_n      = wptr + PTR_W'(wr_accept);
      pop         = 1'b0;
      load_out    = 1'b0;
      rptr_n      = rptr;
      pf_valid_n  = 1'b0;
      rd_addr     = rptr[RAM_DEPTH-1:0];
      out_valid_n = 1'b0;
      if (FWFT != 0) begin
         pop         = rd_accept;
         load_out    = pf_valid & (~out_valid | pop);
         rptr_n      = rptr + PTR_W'(load_out);
         pf_valid_n  = st_count > PTR_W'(load_out);
         rd_addr     = rptr_n[RAM_DEPTH-1:0];
         out_valid_n = load_out | (out_valid & ~pop);
      end else begin
         load_out    = pf_valid;
         rptr_n      = rptr + PTR_W'(rd_accept);
         pf_valid_n  = rd_accept;
         out_valid_n = pf_valid;
      end
      dout_n  = load_out ? rd_data : dout_q;
      level_n = (wptr_n - rptr_n) + ((FWFT != 0) ? PTR_W'(out_valid_n) : '0);

      status_n.full   = (wptr_n[PTR_W-1] != rptr_n[PTR_W-1]) &&
                        (wptr_n[RAM_DEPTH-1:0] == rptr_n[RAM_DEPTH-1:0]);
      status_n.empty  = (FWFT != 0) ? ~out_valid_n : (wptr_n == rptr_n);
      status_n.afull  = level_n >= AFULL_T;
      status_n.aempty = level_n <= AEMPTY_T;
      status_n.ovf    = (WEN & status_q.full) | (status_q.ovf & ~CLR_ERR);
      status_n.udf    = (REN & status_q.empty) | (status_q.udf & ~CLR_ERR);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr      <= '0;
         rptr      <= '0;
         pf_valid  <= 1'b0;
         out_valid <= 1'b0;
         dout_q    <= '0;
         level_q   <= '0;
         status_q  <= STATUS_RST;
      end else begin
         wptr      <= wptr_n;
         rptr      <= rptr_n;
         pf_valid  <= pf_valid_n;
         out_valid <= out_valid_n;
         dout_q    <= dout_n;
         level_q   <= level_n;
         status_q  <= status_n;
      end
   end

   assign DOUT   = dout_q;
   assign DVALID = out_valid;
   assign FULL   = status_q.full;
   assign EMPTY  = status_q.empty;
   assign AFULL  = status_q.afull;
   assign AEMPTY = status_q.aempty;
   assign LEVEL  = level_q;
   assign OVF    = status_q.ovf;
   assign UDF    = status_q.udf;

endmodule

// File: tb/tb_net_bus_sync_fifo.sv
// Directed bench for net_bus_sync_fifo: one standard-mode and one FWFT instance on a shared clock.
module tb_net_bus_sync_fifo;

   logic        clk = 1'b0;
   logic        rst;

   logic [15:0] s_din, s_dout;
   logic        s_wen, s_ren, s_clr, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic [4:0]  s_level;

   logic [15:0] f_din, f_dout;
   logic        f_wen, f_ren, f_clr, f_dvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [4:0]  f_level;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   net_bus_sync_fifo #(.FWFT(0)) dut_std (
      .CLK(clk), .RST(rst), .DIN(s_din), .WEN(s_wen), .REN(s_ren), .CLR_ERR(s_clr),
      .DOUT(s_dout), .DVALID(s_dvalid), .FULL(s_full), .EMPTY(s_empty), .AFULL(s_afull),
      .AEMPTY(s_aempty), .LEVEL(s_level), .OVF(s_ovf), .UDF(s_udf)
   );

   net_bus_sync_fifo #(.FWFT(1)) dut_fw (
      .CLK(clk), .RST(rst), .DIN(f_din), .WEN(f_wen), .REN(f_ren), .CLR_ERR(f_clr),
      .DOUT(f_dout), .DVALID(f_dvalid), .FULL(f_full), .EMPTY(f_empty), .AFULL(f_afull),
      .AEMPTY(f_aempty), .LEVEL(f_level), .OVF(f_ovf), .UDF(f_udf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " level"},  32'(s_level), 32'd0);
      check({tag, " empty"},  32'(s_empty), 32'd1);
      check({tag, " aempty"}, 32'(s_aempty), 32'd1);
      check({tag, " full"},   32'(s_full), 32'd0);
      check({tag, " afull"},  32'(s_afull), 32'd0);
      check({tag, " dvalid"}, 32'(s_dvalid), 32'd0);
      check({tag, " dout"},   32'(s_dout), 32'd0);
      check({tag, " ovf"},    32'(s_ovf), 32'd0);
      check({tag, " udf"},    32'(s_udf), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      s_din = '0; s_wen = 0; s_ren = 0; s_clr = 0;
      f_din = '0; f_wen = 0; f_ren = 0; f_clr = 0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset std");
      check("reset fw empty", 32'(f_empty), 32'd1);
      check("reset fw level", 32'(f_level), 32'd0);

      $display("[TB] fill 16 words");
      for (int i = 1; i <= 16; i++) begin
         s_wen = 1; s_din = 16'(i);
         tick();
         check($sformatf("fill%0d level", i), 32'(s_level), 32'(i));
         check($sformatf("fill%0d afull", i), 32'(s_afull), 32'(i >= 12));
         check($sformatf("fill%0d full", i), 32'(s_full), 32'(i == 16));
         check($sformatf("fill%0d aempty", i), 32'(s_aempty), 32'(i <= 2));
         check($sformatf("fill%0d empty", i), 32'(s_empty), 32'd0);
      end

      $display("[TB] overflow and clear");
      s_din = 16'hDEAD;
      tick();
      s_wen = 0;
      check("ovf set", 32'(s_ovf), 32'd1);
      check("ovf level", 32'(s_level), 32'd16);
      check("ovf full", 32'(s_full), 32'd1);
      s_clr = 1;
      tick();
      s_clr = 0;
      check("ovf cleared", 32'(s_ovf), 32'd0);

      $display("[TB] drain standard mode");
      for (int k = 1; k <= 16; k++) begin
         s_ren = 1;
         tick();
         check($sformatf("drain%0d level", k), 32'(s_level), 32'(16 - k));
         if (k == 1) begin
            check("drain1 dvalid", 32'(s_dvalid), 32'd0);
         end else begin
            check($sformatf("drain%0d dout", k), 32'(s_dout), 32'(k - 1));
            check($sformatf("drain%0d dvalid", k), 32'(s_dvalid), 32'd1);
         end
      end
      check("drain empty", 32'(s_empty), 32'd1);
      s_ren = 0;
      tick();
      check("drain last dout", 32'(s_dout), 32'h0010);
      check("drain last dvalid", 32'(s_dvalid), 32'd1);
      tick();
      check("dvalid pulse ends", 32'(s_dvalid), 32'd0);
      check("dout holds", 32'(s_dout), 32'h0010);

      $display("[TB] underflow");
      s_ren = 1;
      tick();
      check("udf set", 32'(s_udf), 32'd1);
      check("udf dvalid", 32'(s_dvalid), 32'd0);
      s_clr = 1;
      tick();
      check("udf set wins over clear", 32'(s_udf), 32'd1);
      s_ren = 0;
      tick();
      s_clr = 0;
      check("udf cleared", 32'(s_udf), 32'd0);
      check("udf level", 32'(s_level), 32'd0);

      $display("[TB] streaming at level 8");
      for (int i = 0; i < 8; i++) begin
         s_wen = 1; s_din = 16'h0100 + 16'(i);
         tick();
      end
      check("stream start level", 32'(s_level), 32'd8);
      for (int j = 0; j < 40; j++) begin
         s_wen = 1; s_ren = 1; s_din = 16'h0108 + 16'(j);
         tick();
         check($sformatf("stream%0d level", j), 32'(s_level), 32'd8);
         if (j >= 1) begin
            check($sformatf("stream%0d dout", j), 32'(s_dout), 32'h0100 + 32'(j - 1));
         end
      end
      s_wen = 0; s_ren = 0;
      tick();
      check("stream last dout", 32'(s_dout), 32'h0127);
      check("stream end level", 32'(s_level), 32'd8);

      $display("[TB] FWFT");
      f_wen = 1; f_din = 16'h00A5;
      tick();
      f_wen = 0;
      check("fw N dvalid", 32'(f_dvalid), 32'd0);
      check("fw N empty", 32'(f_empty), 32'd1);
      check("fw N level", 32'(f_level), 32'd1);
      tick();
      check("fw N+1 dvalid", 32'(f_dvalid), 32'd0);
      tick();
      check("fw N+2 dvalid", 32'(f_dvalid), 32'd1);
      check("fw N+2 dout", 32'(f_dout), 32'h00A5);
      check("fw N+2 empty", 32'(f_empty), 32'd0);
      check("fw N+2 level", 32'(f_level), 32'd1);
      f_wen = 1; f_din = 16'h00B1;
      tick();
      f_din = 16'h00B2;
      tick();
      f_din = 16'h00B3;
      tick();
      f_wen = 0;
      check("fw loaded level", 32'(f_level), 32'd4);
      check("fw head kept", 32'(f_dout), 32'h00A5);
      f_ren = 1;
      tick();
      check("fw pop1 dout", 32'(f_dout), 32'h00B1);
      check("fw pop1 dvalid", 32'(f_dvalid), 32'd1);
      check("fw pop1 level", 32'(f_level), 32'd3);
      tick();
      check("fw pop2 dout", 32'(f_dout), 32'h00B2);
      check("fw pop2 dvalid", 32'(f_dvalid), 32'd1);
      check("fw pop2 level", 32'(f_level), 32'd2);
      tick();
      check("fw pop3 dout", 32'(f_dout), 32'h00B3);
      check("fw pop3 dvalid", 32'(f_dvalid), 32'd1);
      check("fw pop3 level", 32'(f_level), 32'd1);
      tick();
      check("fw pop4 dvalid", 32'(f_dvalid), 32'd0);
      check("fw pop4 empty", 32'(f_empty), 32'd1);
      check("fw pop4 level", 32'(f_level), 32'd0);
      check("fw no udf yet", 32'(f_udf), 32'd0);
      tick();
      f_ren = 0;
      check("fw udf", 32'(f_udf), 32'd1);

      $display("[TB] reset mid-burst");
      s_ren = 1;
      tick();
      tick();
      tick();
      check("pre-reset level", 32'(s_level), 32'd5);
      rst = 1; s_wen = 1; s_din = 16'hBEEF;
      tick();
      check_reset_state("mid reset");
      rst = 0; s_wen = 0; s_ren = 0;
      tick();
      check("post reset level", 32'(s_level), 32'd0);
      check("post reset dvalid", 32'(s_dvalid), 32'd0);
      check("post reset fw level", 32'(f_level), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
